// File: rtl/calc_pkg.sv
// Shared definitions for the calculator's ASCII character protocol.
package calc_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_E     = 8'h45;
    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        LOAD,
        SEND,
        GAP,
        DONE
    } fmt_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble binary to BCD converter, one bit per cycle.
// The load cycle already shifts in the MSB; done marks the final shift.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int RES_W = 16,
    parameter int NDIG  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [RES_W-1:0]   bin,
    output logic [4*NDIG-1:0]  bcd,
    output logic               done
);

    localparam int CW = $clog2(RES_W + 1);

    logic [RES_W-1:0]  sr_q;
    logic [4*NDIG-1:0] bcd_q;
    logic [CW-1:0]     cnt_q;
    logic              run_q;

    function automatic logic [4*NDIG-1:0] step(
        input logic [4*NDIG-1:0] b,
        input logic              bit_in
    );
        logic [4*NDIG-1:0] a;
        logic [3:0]        nib;
        a = b;
        for (int i = 0; i < NDIG; i++) begin
            nib = b[4*i +: 4];
            a[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        return {a[4*NDIG-2:0], bit_in};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load) begin
            bcd_q <= step('0, bin[RES_W-1]);
            sr_q  <= bin << 1;
            cnt_q <= CW'(1);
            run_q <= 1'b1;
        end else if (run_q) begin
            bcd_q <= step(bcd_q, sr_q[RES_W-1]);
            sr_q  <= sr_q << 1;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(RES_W - 1)) run_q <= 1'b0;
        end
    end

    assign bcd  = bcd_q;
    assign done = run_q && (cnt_q == CW'(RES_W - 1));

endmodule

// File: rtl/res_fmt_tx.sv
// Result formatter: converts an ALU result to ASCII and feeds the UART.
module res_fmt_tx
    import calc_pkg::*;
#(
    parameter int RES_W  = 16,
    parameter int NDIG   = 5,
    parameter int EOL_LF = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RES_W-1:0] res,
    input  logic             neg,
    input  logic             err,
    input  logic             res_vld,
    input  logic             tx_rdy,
    output logic [7:0]       data,
    output logic             strt,
    output logic             busy
);

    localparam int MAXC  = NDIG + 3;
    localparam int PW    = $clog2(MAXC + 1);
    localparam int DEPTH = 2 ** PW;

    fmt_state_t        state_q;
    logic [RES_W-1:0]  res_q;
    logic              neg_q;
    logic              err_q;
    logic [7:0]        data_q;
    logic              strt_q;
    logic              busy_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     len_q;
    logic [PW-1:0]     len_d;
    logic [7:0]        seq_q [DEPTH];
    logic [7:0]        seq_d [DEPTH];
    logic [PW-1:0]     n;
    logic              lead;
    logic [3:0]        dig;
    logic [4*NDIG-1:0] bcd;
    logic              cv_done;
    logic              cv_load;

    assign cv_load = (state_q == IDLE) && res_vld;

    bin2bcd_seq #(
        .RES_W (RES_W),
        .NDIG  (NDIG)
    ) u_b2b (
        .clk  (clk),
        .rst  (rst),
        .load (cv_load),
        .bin  (res),
        .bcd  (bcd),
        .done (cv_done)
    );

    // Character list for the latched result; consumed in LOAD.
    always_comb begin
        seq_d = '{default: 8'h00};
        n     = '0;
        lead  = 1'b1;
        dig   = '0;
        if (err_q) begin
            seq_d[0] = CH_E;
            seq_d[1] = CH_R;
            seq_d[2] = CH_R;
            n        = PW'(3);
        end else begin
            if (neg_q && res_q != '0) begin
                seq_d[n] = CH_MINUS;
                n        = n + PW'(1);
            end
            for (int i = NDIG - 1; i >= 0; i--) begin
                dig = bcd[4*i +: 4];
                if (dig != 4'd0 || i == 0) lead = 1'b0;
                if (!lead) begin
                    seq_d[n] = CH_0 + {4'h0, dig};
                    n        = n + PW'(1);
                end
            end
        end
        seq_d[n] = CH_CR;
        n        = n + PW'(1);
        if (EOL_LF != 0) begin
            seq_d[n] = CH_LF;
            n        = n + PW'(1);
        end
        len_d = n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 8'h00;
            strt_q  <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            len_q   <= '0;
            seq_q   <= '{default: 8'h00};
        end else begin
            strt_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (res_vld) begin
                        res_q   <= res;
                        neg_q   <= neg;
                        err_q   <= err;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    if (cv_done) state_q <= LOAD;
                end
                LOAD: begin
                    seq_q   <= seq_d;
                    len_q   <= len_d;
                    ptr_q   <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    if (tx_rdy) begin
                        strt_q  <= 1'b1;
                        data_q  <= seq_q[ptr_q];
                        ptr_q   <= ptr_q + PW'(1);
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (ptr_q == len_q) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        state_q <= SEND;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data = data_q;
    assign strt = strt_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_res_fmt_tx.sv
// Directed bench for res_fmt_tx: byte streams, latency, handshake, reset.
module tb_res_fmt_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] res;
    logic        neg;
    logic        err;
    logic        res_vld;
    logic        tx_rdy;
    logic [7:0]  data;
    logic        strt;
    logic        busy;

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    res_fmt_tx #(
        .RES_W  (16),
        .NDIG   (5),
        .EOL_LF (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .res     (res),
        .neg     (neg),
        .err     (err),
        .res_vld (res_vld),
        .tx_rdy  (tx_rdy),
        .data    (data),
        .strt    (strt),
        .busy    (busy)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic [15:0] r, input logic n,
                           input logic e, input bit slow,
                           input int dup_at, input int rst_after,
                           input string tag);
        int nb, first, lowcnt, extra, want;
        bit fin;
        nb = 0; first = -1; lowcnt = 0; extra = 0; fin = 1'b0;
        @(negedge clk);
        res = r; neg = n; err = e; res_vld = 1'b1; tx_rdy = !slow;
        for (int k = 1; k <= 2000 && !fin; k++) begin
            @(negedge clk);
            res_vld = (k == dup_at);
            if (k == dup_at) res = 16'd999;
            if (k == 1) chk(busy, 1, {tag, "_busy"});
            if (strt) begin
                if (first < 0) first = k;
                if (slow) chk(tx_rdy, 1, {tag, "_rdy"});
                if (nb < exp_q.size())
                    chk(data, exp_q[nb], {tag, "_byte"});
                nb++;
                if (slow) begin
                    tx_rdy = 1'b0;
                    lowcnt = 0;
                end
                if (nb == rst_after) begin
                    rst = 1'b1;
                    @(negedge clk);
                    chk(strt, 0, {tag, "_rst_strt"});
                    chk(busy, 0, {tag, "_rst_busy"});
                    chk(data, 0, {tag, "_rst_data"});
                    rst = 1'b0;
                    fin = 1'b1;
                end
            end else if (slow && !tx_rdy) begin
                lowcnt++;
                if (lowcnt >= 50) tx_rdy = 1'b1;
            end
            if (k > 1 && !busy) fin = 1'b1;
        end
        chk(fin, 1, {tag, "_timeout"});
        want = (rst_after > 0) ? rst_after : exp_q.size();
        chk(nb, want, {tag, "_count"});
        if (!slow && rst_after == 0) chk(first, 18, {tag, "_latency"});
        repeat (4) begin
            @(negedge clk);
            if (strt) extra++;
        end
        chk(extra, 0, {tag, "_extra"});
        tx_rdy = 1'b1;
    endtask

    initial begin
        rst = 1'b1; res = '0; neg = 1'b0; err = 1'b0;
        res_vld = 1'b0; tx_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk(strt, 0, "reset_strt");
        chk(busy, 0, "reset_busy");
        chk(data, 0, "reset_data");
        rst = 1'b0;

        exp_q = '{8'h31, 8'h37, 8'h0D, 8'h0A};
        run_req(16'd17, 1'b0, 1'b0, 1'b0, -1, 0, "r17");

        exp_q = '{8'h30, 8'h0D, 8'h0A};
        run_req(16'd0, 1'b0, 1'b0, 1'b0, -1, 0, "zero");

        exp_q = '{8'h30, 8'h0D, 8'h0A};
        run_req(16'd0, 1'b1, 1'b0, 1'b0, -1, 0, "negzero");

        exp_q = '{8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 8'h0D, 8'h0A};
        run_req(16'd65535, 1'b0, 1'b0, 1'b0, -1, 0, "max");

        exp_q = '{8'h2D, 8'h35, 8'h0D, 8'h0A};
        run_req(16'd5, 1'b1, 1'b0, 1'b0, -1, 0, "neg5");

        exp_q = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
        run_req(16'd1234, 1'b0, 1'b1, 1'b0, -1, 0, "err");

        exp_q = '{8'h31, 8'h30, 8'h30, 8'h0D, 8'h0A};
        run_req(16'd100, 1'b0, 1'b0, 1'b0, -1, 0, "r100");

        exp_q = '{8'h2D, 8'h33, 8'h30, 8'h35, 8'h0D, 8'h0A};
        run_req(16'd305, 1'b1, 1'b0, 1'b1, -1, 0, "slow");

        exp_q = '{8'h39, 8'h0D, 8'h0A};
        run_req(16'd9, 1'b0, 1'b0, 1'b0, 5, 0, "dup");

        exp_q = '{8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 8'h0D, 8'h0A};
        run_req(16'd65535, 1'b0, 1'b0, 1'b0, -1, 2, "abort");

        exp_q = '{8'h34, 8'h32, 8'h0D, 8'h0A};
        run_req(16'd42, 1'b0, 1'b0, 1'b0, -1, 0, "r42");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
